// File: rtl/ula_seq_exec.sv
// Execute-stage ALU: decodes ula_operation/func, runs logic ops in one cycle and shifts
// iteratively SHIFT_STEP bits per cycle. Define ULA_SEQ_OVERFLOW_EN to add the overflow output.
module ula_seq_exec #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1,
    localparam int unsigned SHW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ula_operation,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ULA_SEQ_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [3:0]       operation
);

    localparam int unsigned SW = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRA  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRAV = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_SLLV = 4'b1110;
    localparam logic [3:0] OP_SRLV = 4'b1111;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic [SHW-1:0]   rem_q, rem_d;

    logic [3:0]       dec_op;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             dec_is_shift;
    logic             dec_is_var;
    logic [SHW-1:0]   dec_amt;
    logic [SW-1:0]    step;
    logic             accept;

    function automatic logic [3:0] decode(input logic [3:0] uop, input logic [5:0] fn);
        logic [3:0] op;
        op = OP_AND;
        case (uop)
            4'b0000: op = OP_ADD;
            4'b0001: op = OP_SUB;
            4'b0011: op = OP_SLT;
            4'b1000: op = OP_SLTU;
            4'b0100: op = OP_AND;
            4'b0101: op = OP_OR;
            4'b0110: op = OP_XOR;
            4'b0111: op = OP_LUI;
            4'b0010: begin
                case (fn)
                    6'b000000: op = OP_SLL;
                    6'b000010: op = OP_SRL;
                    6'b000011: op = OP_SRA;
                    6'b000100: op = OP_SLLV;
                    6'b000110: op = OP_SRLV;
                    6'b000111: op = OP_SRAV;
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    default:   op = OP_AND;
                endcase
            end
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // Decode and single-cycle ALU on the incoming request
    always_comb begin
        dec_op       = decode(ula_operation, func);
        sum          = a + b;
        diff         = a - b;
        dec_is_var   = (dec_op == OP_SLLV) || (dec_op == OP_SRLV) || (dec_op == OP_SRAV);
        dec_is_shift = dec_is_var || (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
        dec_amt      = dec_is_var ? a[SHW-1:0] : shamt;
        alu_res      = '0;
        case (dec_op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_LUI:  alu_res = b << (WIDTH / 2);
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    assign accept = (state_q == IDLE) && in_valid;
    assign step   = (SW'(rem_q) > SW'(SHIFT_STEP)) ? SW'(SHIFT_STEP) : SW'(rem_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            op_q     <= OP_AND;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = dec_op;
                    if (dec_is_shift) begin
                        // Shifted value is staged in the result register
                        result_d = b;
                        rem_d    = dec_amt;
                        state_d  = (dec_amt == '0) ? HOLD : SHIFT;
                    end else begin
                        result_d = alu_res;
                        rem_d    = '0;
                        state_d  = HOLD;
                    end
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_SLL, OP_SLLV: result_d = result_q << step;
                    OP_SRL, OP_SRLV: result_d = result_q >> step;
                    default:         result_d = WIDTH'($signed(result_q) >>> step);
                endcase
                rem_d = rem_q - SHW'(step);
                if (rem_d == '0) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ULA_SEQ_OVERFLOW_EN
    logic ovf_q;
    logic ovf_c;

    // Signed overflow: equal operand signs (~b for SUB) and a result sign that differs
    always_comb begin
        ovf_c = 1'b0;
        if (dec_op == OP_ADD) begin
            ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (dec_op == OP_SUB) begin
            ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= ovf_c;
        end
    end

    assign overflow = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign operation = op_q;

endmodule

// File: tb/tb_ula_seq_exec.sv
// Directed bench for ula_seq_exec: one SHIFT_STEP=1 instance and one SHIFT_STEP=4 instance.
module tb_ula_seq_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [3:0]  ula_operation, operation;
    logic [5:0]  func;
    logic [31:0] a, b, result;
    logic [4:0]  shamt;

    logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_zero;
    logic [3:0]  f_ula_operation, f_operation;
    logic [5:0]  f_func;
    logic [31:0] f_a, f_b, f_result;
    logic [4:0]  f_shamt;
`ifdef ULA_SEQ_OVERFLOW_EN
    logic        overflow, f_overflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ula_seq_exec #(.WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ula_operation(ula_operation), .func(func), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
`ifdef ULA_SEQ_OVERFLOW_EN
        .overflow(overflow),
`endif
        .operation(operation)
    );

    ula_seq_exec #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .ula_operation(f_ula_operation), .func(f_func), .a(f_a), .b(f_b), .shamt(f_shamt),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .result(f_result), .zero(f_zero),
`ifdef ULA_SEQ_OVERFLOW_EN
        .overflow(f_overflow),
`endif
        .operation(f_operation)
    );

    // Present one request at a negedge, then wait (bounded) for out_valid
    task automatic do_req(input logic [3:0] uop, input logic [5:0] fn, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [4:0] sh, output int lat);
        in_valid = 1'b1; ula_operation = uop; func = fn; a = aa; b = bb; shamt = sh;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (operation !== 4'b0000) begin failures++; $display("FAIL reset_operation got=%b exp=0000", operation); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_shift;
        in_valid = 1'b1; ula_operation = 4'b0010; func = 6'b000000; a = 0; b = 32'h1; shamt = 5'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midshift_busy in_ready=%b out_valid=%b exp=0/0", in_ready, out_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midshift_rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL midshift_rst_result got=%h zero=%b exp=0/1", result, zero); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midshift_rst_in_ready got=%b exp=0", in_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midshift_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
        repeat (25) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midshift_discarded out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_add_overflow;
        int lat;
        do_req(4'b0010, 6'b100000, 32'h7FFF_FFFF, 32'h1, 5'd0, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (result !== 32'h8000_0000) begin failures++; $display("FAIL add_result got=%h exp=80000000", result); end
        checks++; if (operation !== 4'b0010 || zero !== 1'b0) begin failures++; $display("FAIL add_op_zero op=%b zero=%b exp=0010/0", operation, zero); end
`ifdef ULA_SEQ_OVERFLOW_EN
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL add_overflow got=%b exp=1", overflow); end
`endif
        consume();
        do_req(4'b0001, 6'b0, 32'h0000_0003, 32'h0000_0005, 5'd0, lat);
        checks++; if (result !== 32'hFFFF_FFFE || operation !== 4'b0110) begin failures++; $display("FAIL sub_neg result=%h op=%b exp=fffffffe/0110", result, operation); end
`ifdef ULA_SEQ_OVERFLOW_EN
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sub_no_overflow got=%b exp=0", overflow); end
`endif
        consume();
    endtask

    task automatic test_srav;
        int lat;
        in_valid = 1'b1; ula_operation = 4'b0010; func = 6'b000111; a = 32'h4; b = 32'h8000_0000; shamt = 5'd0;
        @(negedge clk);
        // Competing request while busy must be ignored
        in_valid = 1'b1; ula_operation = 4'b0000; func = 6'b0; a = 32'h1; b = 32'h1;
        lat = 1;
        while (!out_valid && lat < 200) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL srav_in_ready cycle=%0d got=%b exp=0", lat, in_ready); end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        checks++; if (lat !== 5) begin failures++; $display("FAIL srav_latency got=%0d exp=5", lat); end
        checks++; if (result !== 32'hF800_0000 || operation !== 4'b1010) begin failures++; $display("FAIL srav_result result=%h op=%b exp=f8000000/1010", result, operation); end
        consume();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL srav_not_queued out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_slt;
        int lat;
        do_req(4'b1000, 6'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, lat);
        checks++; if (result !== 32'h0 || operation !== 4'b1000 || zero !== 1'b1) begin failures++; $display("FAIL sltu result=%h op=%b zero=%b exp=0/1000/1", result, operation, zero); end
        consume();
        do_req(4'b0011, 6'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, lat);
        checks++; if (result !== 32'h1 || operation !== 4'b0111) begin failures++; $display("FAIL slt result=%h op=%b exp=1/0111", result, operation); end
        consume();
        do_req(4'b0010, 6'b101011, 32'h1, 32'hFFFF_FFFF, 5'd0, lat);
        checks++; if (result !== 32'h1 || operation !== 4'b1000) begin failures++; $display("FAIL rtype_sltu result=%h op=%b exp=1/1000", result, operation); end
        consume();
    endtask

    task automatic test_backpressure;
        int lat;
        do_req(4'b0001, 6'b0, 32'h5, 32'h5, 5'd0, lat);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || operation !== 4'b0110 || in_ready !== 1'b0) begin
                failures++; $display("FAIL hold_stable cycle=%0d ov=%b res=%h zero=%b op=%b rdy=%b exp=1/0/1/0110/0", i, out_valid, result, zero, operation, in_ready);
            end
            @(negedge clk);
        end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_misc_ops;
        int lat;
        do_req(4'b0111, 6'b0, 32'h0, 32'h0000_1234, 5'd0, lat);
        checks++; if (result !== 32'h1234_0000 || operation !== 4'b1011) begin failures++; $display("FAIL lui result=%h op=%b exp=12340000/1011", result, operation); end
        consume();
        do_req(4'b1111, 6'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, lat);
        checks++; if (result !== 32'hF000_F000 || operation !== 4'b0000) begin failures++; $display("FAIL unknown_and result=%h op=%b exp=f000f000/0000", result, operation); end
        consume();
        do_req(4'b0010, 6'b100111, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, lat);
        checks++; if (result !== 32'hF0F0_FF00 || operation !== 4'b1100) begin failures++; $display("FAIL nor result=%h op=%b exp=f0f0ff00/1100", result, operation); end
        consume();
        do_req(4'b0110, 6'b0, 32'h0000_00FF, 32'h0000_000F, 5'd0, lat);
        checks++; if (result !== 32'h0000_00F0 || operation !== 4'b1101) begin failures++; $display("FAIL xor result=%h op=%b exp=000000f0/1101", result, operation); end
        consume();
        do_req(4'b0010, 6'b000010, 32'h0, 32'h0000_0080, 5'd0, lat);
        checks++; if (lat !== 1 || result !== 32'h80 || operation !== 4'b0101) begin failures++; $display("FAIL srl_zero lat=%0d result=%h op=%b exp=1/00000080/0101", lat, result, operation); end
        consume();
        do_req(4'b0010, 6'b111111, 32'h0000_0F0F, 32'h0000_00FF, 5'd0, lat);
        checks++; if (result !== 32'h0000_000F || operation !== 4'b0000) begin failures++; $display("FAIL rtype_default result=%h op=%b exp=0000000f/0000", result, operation); end
        consume();
    endtask

    task automatic test_back_to_back;
        int lat;
        do_req(4'b0000, 6'b0, 32'h2, 32'h3, 5'd0, lat);
        checks++; if (result !== 32'h5) begin failures++; $display("FAIL b2b_first result=%h exp=5", result); end
        in_valid = 1'b1; ula_operation = 4'b0101; a = 32'hF0; b = 32'h0F;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'hFF || operation !== 4'b0001) begin failures++; $display("FAIL b2b_second ov=%b result=%h op=%b exp=1/000000ff/0001", out_valid, result, operation); end
        consume();
    endtask

    task automatic test_step4;
        int lat;
        f_in_valid = 1'b1; f_ula_operation = 4'b0010; f_func = 6'b000000; f_a = 0; f_b = 32'h1; f_shamt = 5'd9;
        @(negedge clk);
        f_in_valid = 1'b0;
        lat = 1;
        while (!f_out_valid && lat < 200) begin @(negedge clk); lat++; end
        checks++; if (lat !== 4) begin failures++; $display("FAIL step4_sll_latency got=%0d exp=4", lat); end
        checks++; if (f_result !== 32'h200 || f_operation !== 4'b0011) begin failures++; $display("FAIL step4_sll result=%h op=%b exp=00000200/0011", f_result, f_operation); end
        f_out_ready = 1'b1; @(negedge clk); f_out_ready = 1'b0;
        f_in_valid = 1'b1; f_func = 6'b000011; f_b = 32'h8000_0000; f_shamt = 5'd6;
        @(negedge clk);
        f_in_valid = 1'b0;
        lat = 1;
        while (!f_out_valid && lat < 200) begin @(negedge clk); lat++; end
        checks++; if (lat !== 3 || f_result !== 32'hFE00_0000 || f_operation !== 4'b0100) begin failures++; $display("FAIL step4_sra lat=%0d result=%h op=%b exp=3/fe000000/0100", lat, f_result, f_operation); end
        f_out_ready = 1'b1; @(negedge clk); f_out_ready = 1'b0;
    endtask

    initial begin
        in_valid = 0; out_ready = 0; ula_operation = 0; func = 0; a = 0; b = 0; shamt = 0;
        f_in_valid = 0; f_out_ready = 0; f_ula_operation = 0; f_func = 0; f_a = 0; f_b = 0; f_shamt = 0;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_reset_mid_shift();
        test_add_overflow();
        test_srav();
        test_slt();
        test_backpressure();
        test_misc_ops();
        test_back_to_back();
        test_step4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ula_seq_exec.md
Name: ula_seq_exec

Overview:
- Parametrised successor to the single-cycle ULA control decoder: decodes ula_operation/func into a 4-bit operation code and executes it on WIDTH-bit operands.
- Logic ops complete in one cycle; shifts run iteratively, SHIFT_STEP bits per cycle, trading area for latency.
- Sits in the execute stage of the multicycle datapath, between the register-read latches and the writeback mux. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be ≥8 and even.
- SHIFT_STEP, 1, bits shifted per cycle; power of two, ≤ WIDTH.
- SHW (localparam), $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- ula_operation  in  4  main-control ALU class.
- func  in  6  R-type function field.
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt/immediate.
- shamt  in  SHW  immediate shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- operation  out  4  decoded operation code of the latched request.

Behaviour:
- Operation codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRA 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRAV 1010, LUI 1011, NOR 1100, XOR 1101, SLLV 1110, SRLV 1111.
- Decode by ula_operation:
  - 0000 ADD; 0001 SUB; 0011 SLT; 1000 SLTU; 0100 AND; 0101 OR; 0110 XOR; 0111 LUI.
  - 0010 R-type by func: 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV, 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU (distinct code, unsigned compare), any other func AND.
  - Any other ula_operation: AND.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - SLT is a signed compare a<b; SLTU is an unsigned compare. Both return zero-extended 1/0.
  - LUI = b << (WIDTH/2).
- Shifts:
  - Shifted value is b.
  - Amount is shamt for SLL/SRL/SRA, and a[SHW-1:0] for SLLV/SRLV/SRAV.
  - SRA/SRAV fill with b[WIDTH-1].
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - in_valid accepted → latch operands, decoded operation, and remaining amount.
  - Non-shift op, or shift with amount 0: result registered, go to HOLD. out_valid is asserted the cycle after acceptance (latency 1).
  - Shift with amount >0: go to SHIFT.
- SHIFT:
  - Each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining.
  - When remaining reaches 0, go to HOLD.
  - Total latency = 1 + ceil(amount/SHIFT_STEP) cycles.
  - in_ready=0.
- HOLD:
  - out_valid=1; result, zero and operation stable.
  - in_ready=0.
  - out_ready=1 → return to IDLE.
  - A back-to-back request is accepted no earlier than the cycle after the out_valid/out_ready handshake.
- No input change affects a request once latched; in_valid while busy is ignored (not queued).
- zero is combinational from the registered result.
- Reset (synchronous, any state, including mid-shift): state IDLE, in_ready=1 (after reset deasserts), out_valid=0, result=0, zero=1, operation=0000. In-flight request is discarded.
- While reset=1: in_ready=0.

Optional Feature:
- Macro: ULA_SEQ_OVERFLOW_EN.
- Defined: adds output overflow (1 bit).
  - Set with the result for ADD/SUB when signed overflow occurs (operand signs equal and result sign differs, for SUB using ~b).
  - 0 for all other ops.
  - Registered with result; reset value 0.
- Undefined: port absent; no overflow logic.

Test Plan:
- Reset mid-SHIFT (SLL, shamt=20) → next cycle out_valid=0, result=0, zero=1, in_ready=1 after reset release.
- R-type ADD a=0x7FFFFFFF, b=1 → out_valid 1 cycle after accept, result=0x80000000, operation=0010, zero=0; with ULA_SEQ_OVERFLOW_EN, overflow=1.
- SRAV a=4, b=0x80000000, SHIFT_STEP=1 → result=0xF8000000 after 5 cycles; in_ready=0 throughout; second in_valid during SHIFT ignored.
- SLTU vs SLT with a=0xFFFFFFFF, b=1 → SLTU result 0 (operation 1000), SLT result 1 (operation 0111).
- Backpressure: SUB a=b=5 with out_ready=0 for 3 cycles → result=0, zero=1, held stable; IDLE the cycle after out_ready=1.
- SHIFT_STEP=4, SLL shamt=9, b=1 → result=0x200, latency 4 cycles; LUI b=0x1234 → 0x12340000; unknown ula_operation 1111 → AND.
